morra_round_sequencer: RTL and testbench
========================================

# morra_round_sequencer

Round sequencer for the `MorraCinese` game core. It collects one move per round from each of two independent player interfaces using valid/ready handshakes, and applies timeout forfeits. It issues each round to the core as a single-cycle drive, captures the core's `manche`/`partita` result, and stops issuing once the core reports a finished match. It sits between the player front-ends and the core, and it is the only driver of the core's `primo`, `secondo` and `inizia` inputs.

## Interface
- `TIMEOUT`, default 16: cycles to wait for the second player after the first move is latched (valid range 1..255).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new match; honoured only in IDLE and DONE.
- `p1_valid`  in  1  player 1 move valid.
- `p1_move`  in  2  player 1 move: 01, 10 or 11 legal; 00 is an invalid move.
- `p1_ready`  out  1  sequencer can accept a player 1 move.
- `p2_valid`, `p2_move`, `p2_ready`: same as the player 1 signals, for player 2.
- `core_primo`  out  2  drives core `primo`.
- `core_secondo`  out  2  drives core `secondo`.
- `core_inizia`  out  1  drives core `inizia`.
- `core_manche`  in  2  core round result: 00 invalid round, 01 P1 wins, 10 P2 wins, 11 draw.
- `core_partita`  in  2  core match result: 00 ongoing, 01 P1 wins, 10 P2 wins, 11 draw.
- `res_valid`  out  1  one-cycle pulse when `res_manche`/`res_partita` update.
- `res_manche`  out  2  last captured round result.
- `res_partita`  out  2  last captured match result.
- `round_count`  out  8  valid rounds played in the current match; saturates at 255.
- `busy`  out  1  high in every state except IDLE and DONE.
- `match_over`  out  1  high in DONE.

## Operation
- States: IDLE, COLLECT, ISSUE, CAPTURE, DONE.
- IDLE:
  - Both ready signals are low.
  - `start` moves to COLLECT. On that transition: set `first_pending`=1, clear `round_count`, clear both move latches.
- COLLECT:
  - `pX_ready` = NOT `have_pX`.
  - A handshake (`pX_valid` and `pX_ready`) latches `pX_move` and sets `have_pX`. Both players may handshake in the same cycle.
  - Later `valid` pulses from an already-latched player are not accepted, because its ready is low.
  - When both `have` flags are set, go to ISSUE.
- Timeout in COLLECT:
  - The 8-bit timer is cleared on entry to COLLECT. It counts only while exactly one `have` flag is set.
  - When the timer reaches `TIMEOUT`-1 and one player is still missing, go to ISSUE. The missing player's move is forced to 00, so the core scores the round as a forfeit.
  - If no player has moved, the timer never runs and the state waits indefinitely.
- ISSUE (1 cycle):
  - `core_primo`/`core_secondo` = latched moves.
  - `core_inizia` = `first_pending`.
  - Next state is CAPTURE.
- Outside ISSUE: `core_primo`, `core_secondo` and `core_inizia` are driven to 0.
- CAPTURE (1 cycle):
  - Register `core_manche`/`core_partita` into `res_*` and pulse `res_valid`.
  - Increment `round_count` if `core_manche`≠00.
  - Clear `first_pending` and the latches.
  - If `core_partita`≠00, go to DONE; otherwise go to COLLECT.
- DONE:
  - `res_*` and `round_count` are held.
  - `start` moves to COLLECT with the same initialisation as from IDLE, so the next ISSUE carries `core_inizia`=1 and starts a new match.
- `start` in COLLECT, ISSUE or CAPTURE is ignored.

## Timing
- Reset values: state=IDLE; all outputs are 0, including `res_*`, `round_count`, `busy`, `match_over` and both ready signals; latches and timer are cleared.
- Reset asserted mid-round discards any latched moves immediately. No core drive is issued.
- The core is registered. Inputs driven in ISSUE are sampled at the end of that cycle, and `core_manche`/`core_partita` are valid during CAPTURE.
- Latency from the second handshake to `res_valid`: the handshake edge moves to ISSUE, the next edge moves to CAPTURE, and `res_valid` is high during CAPTURE. That is `res_valid` 2 cycles after the handshake cycle.
- Minimum round period: 3 cycles (COLLECT, ISSUE, CAPTURE) when both players are valid on entry to COLLECT.
- Timeout round: ISSUE is entered exactly `TIMEOUT` cycles after the first handshake cycle.
- `res_valid` is never high for 2 consecutive cycles.

## Test plan
- Reset with `p1_valid`=`p2_valid`=1 -> `p1_ready`=`p2_ready`=0, all outputs 0, no handshake accepted.
- `start`, then P1=10 and P2=10 in the same cycle -> ISSUE drives 10/10 with `core_inizia`=1. `res_valid` fires 2 cycles later with the core's result. `round_count`=1 if `manche`≠00.
- Start a match, P1=01, P2 silent, `TIMEOUT`=4 -> ISSUE 4 cycles after the P1 handshake with `core_secondo`=00. The captured `manche` is 00 and `round_count` is unchanged.
- P1 sends two valid moves before P2 -> the second P1 move is not accepted (`p1_ready`=0) until CAPTURE completes. The second round uses `core_inizia`=0.
- Run rounds until `core_partita`=01 -> DONE with `match_over`=1 and `res_partita`=01. Further moves are not accepted. `start` -> next ISSUE has `core_inizia`=1 and `round_count` restarts at 0.
- Assert `rst_n`=0 during COLLECT with P1 latched, then release -> IDLE; the next match's first ISSUE does not carry the stale P1 move.

Source files
------------

// File: rtl/morra_round_sequencer.sv
// Round sequencer for the MorraCinese game core.
// Collects one move per round from each player over valid/ready, forfeits a
// silent player after TIMEOUT cycles, drives the core for exactly one cycle
// per round, captures the round/match result and stops once the match ends.
module morra_round_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       p1_valid,
    input  logic [1:0] p1_move,
    output logic       p1_ready,
    input  logic       p2_valid,
    input  logic [1:0] p2_move,
    output logic       p2_ready,
    output logic [1:0] core_primo,
    output logic [1:0] core_secondo,
    output logic       core_inizia,
    input  logic [1:0] core_manche,
    input  logic [1:0] core_partita,
    output logic       res_valid,
    output logic [1:0] res_manche,
    output logic [1:0] res_partita,
    output logic [7:0] round_count,
    output logic       busy,
    output logic       match_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_t;

    // Last timer value before the silent player is forfeited.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic       have_p1_reg, have_p2_reg;
    logic [1:0] move_p1_reg, move_p2_reg;
    logic       first_pending_reg;
    logic [7:0] timer_reg;
    logic [7:0] round_count_reg;
    logic [1:0] res_manche_reg, res_partita_reg;

    logic p1_hs, p2_hs;
    logic got_p1, got_p2;
    logic one_pending;
    logic timed_out;
    logic start_match;

    // A move counts as "got" in the very cycle it is handshaken, so the
    // timeout window starts at the first handshake cycle itself.
    assign p1_hs       = p1_valid & p1_ready;
    assign p2_hs       = p2_valid & p2_ready;
    assign got_p1      = have_p1_reg | p1_hs;
    assign got_p2      = have_p2_reg | p2_hs;
    assign one_pending = got_p1 ^ got_p2;
    assign timed_out   = one_pending && (timer_reg == TIMEOUT_LAST);
    assign start_match = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if ((got_p1 && got_p2) || timed_out) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_next = (core_partita != 2'b00) ? S_DONE : S_COLLECT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Move latches, forfeit timer, round counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_p1_reg       <= 1'b0;
            have_p2_reg       <= 1'b0;
            move_p1_reg       <= 2'b00;
            move_p2_reg       <= 2'b00;
            first_pending_reg <= 1'b0;
            timer_reg         <= 8'd0;
            round_count_reg   <= 8'd0;
            res_manche_reg    <= 2'b00;
            res_partita_reg   <= 2'b00;
        end else if (start_match) begin
            have_p1_reg       <= 1'b0;
            have_p2_reg       <= 1'b0;
            move_p1_reg       <= 2'b00;
            move_p2_reg       <= 2'b00;
            first_pending_reg <= 1'b1;
            timer_reg         <= 8'd0;
            round_count_reg   <= 8'd0;
        end else if (state_reg == S_COLLECT) begin
            if (p1_hs) begin
                move_p1_reg <= p1_move;
                have_p1_reg <= 1'b1;
            end
            if (p2_hs) begin
                move_p2_reg <= p2_move;
                have_p2_reg <= 1'b1;
            end
            if (one_pending) begin
                timer_reg <= timer_reg + 8'd1;
            end
        end else if (state_reg == S_CAPTURE) begin
            res_manche_reg  <= core_manche;
            res_partita_reg <= core_partita;
            if ((core_manche != 2'b00) && (round_count_reg != 8'hFF)) begin
                round_count_reg <= round_count_reg + 8'd1;
            end
            // A missing player's latch stays 00, which is what forces the
            // forfeit on the next timed-out round.
            have_p1_reg       <= 1'b0;
            have_p2_reg       <= 1'b0;
            move_p1_reg       <= 2'b00;
            move_p2_reg       <= 2'b00;
            first_pending_reg <= 1'b0;
            timer_reg         <= 8'd0;
        end
    end

    // Output decode; results are forwarded during CAPTURE so they are
    // valid together with the res_valid pulse.
    always_comb begin
        p1_ready     = 1'b0;
        p2_ready     = 1'b0;
        core_primo   = 2'b00;
        core_secondo = 2'b00;
        core_inizia  = 1'b0;
        res_valid    = 1'b0;
        res_manche   = res_manche_reg;
        res_partita  = res_partita_reg;
        round_count  = round_count_reg;
        busy         = (state_reg != S_IDLE) && (state_reg != S_DONE);
        match_over   = (state_reg == S_DONE);
        case (state_reg)
            S_COLLECT: begin
                p1_ready = ~have_p1_reg;
                p2_ready = ~have_p2_reg;
            end
            S_ISSUE: begin
                core_primo   = move_p1_reg;
                core_secondo = move_p2_reg;
                core_inizia  = first_pending_reg;
            end
            S_CAPTURE: begin
                res_valid   = 1'b1;
                res_manche  = core_manche;
                res_partita = core_partita;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_morra_round_sequencer.sv
// Directed testbench for morra_round_sequencer with a 4-cycle timeout.
module tb_morra_round_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       p1_valid;
    logic [1:0] p1_move;
    logic       p1_ready;
    logic       p2_valid;
    logic [1:0] p2_move;
    logic       p2_ready;
    logic [1:0] core_primo;
    logic [1:0] core_secondo;
    logic       core_inizia;
    logic [1:0] core_manche;
    logic [1:0] core_partita;
    logic       res_valid;
    logic [1:0] res_manche;
    logic [1:0] res_partita;
    logic [7:0] round_count;
    logic       busy;
    logic       match_over;

    int vectors;
    int miscompares;

    morra_round_sequencer #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .p1_valid     (p1_valid),
        .p1_move      (p1_move),
        .p1_ready     (p1_ready),
        .p2_valid     (p2_valid),
        .p2_move      (p2_move),
        .p2_ready     (p2_ready),
        .core_primo   (core_primo),
        .core_secondo (core_secondo),
        .core_inizia  (core_inizia),
        .core_manche  (core_manche),
        .core_partita (core_partita),
        .res_valid    (res_valid),
        .res_manche   (res_manche),
        .res_partita  (res_partita),
        .round_count  (round_count),
        .busy         (busy),
        .match_over   (match_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        p1_valid = 1'b1; p1_move = 2'b11;
        p2_valid = 1'b1; p2_move = 2'b11;
        core_manche = 2'b00; core_partita = 2'b00;
        tick(); tick();
        vectors++; if (p1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_p1_ready got %b want 0", p1_ready); end
        vectors++; if (p2_ready !== 1'b0) begin miscompares++; $display("FAIL reset_p2_ready got %b want 0", p2_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (match_over !== 1'b0) begin miscompares++; $display("FAIL reset_match_over got %b want 0", match_over); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        vectors++; if (round_count !== 8'd0) begin miscompares++; $display("FAIL reset_round_count got %0d want 0", round_count); end
        vectors++; if ({core_primo, core_secondo, core_inizia} !== 5'b0) begin miscompares++; $display("FAIL reset_core_drive got %b want 00000", {core_primo, core_secondo, core_inizia}); end
        vectors++; if ({res_manche, res_partita} !== 4'b0) begin miscompares++; $display("FAIL reset_res got %b want 0000", {res_manche, res_partita}); end
        rst_n = 1'b1;
        tick(); tick();
        vectors++; if ({p1_ready, p2_ready, busy} !== 3'b000) begin miscompares++; $display("FAIL idle_after_reset got %b want 000", {p1_ready, p2_ready, busy}); end
        p1_valid = 1'b0; p2_valid = 1'b0;
    endtask

    task automatic test_same_cycle();
        core_manche = 2'b01; core_partita = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if ({p1_ready, p2_ready, busy} !== 3'b111) begin miscompares++; $display("FAIL collect_ready got %b want 111", {p1_ready, p2_ready, busy}); end
        p1_valid = 1'b1; p1_move = 2'b10;
        p2_valid = 1'b1; p2_move = 2'b10;
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        vectors++; if (core_primo !== 2'b10) begin miscompares++; $display("FAIL same_primo got %b want 10", core_primo); end
        vectors++; if (core_secondo !== 2'b10) begin miscompares++; $display("FAIL same_secondo got %b want 10", core_secondo); end
        vectors++; if (core_inizia !== 1'b1) begin miscompares++; $display("FAIL same_inizia got %b want 1", core_inizia); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL same_issue_res_valid got %b want 0", res_valid); end
        tick();
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL same_res_valid got %b want 1", res_valid); end
        vectors++; if ({res_manche, res_partita} !== 4'b0100) begin miscompares++; $display("FAIL same_res got %b want 0100", {res_manche, res_partita}); end
        vectors++; if (core_inizia !== 1'b0) begin miscompares++; $display("FAIL capture_inizia got %b want 0", core_inizia); end
        tick();
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL same_res_valid_drop got %b want 0", res_valid); end
        vectors++; if (round_count !== 8'd1) begin miscompares++; $display("FAIL same_round_count got %0d want 1", round_count); end
        vectors++; if (res_manche !== 2'b01) begin miscompares++; $display("FAIL same_res_held got %b want 01", res_manche); end
        vectors++; if (p1_ready !== 1'b1) begin miscompares++; $display("FAIL same_back_collect got %b want 1", p1_ready); end
    endtask

    task automatic test_timeout();
        core_manche = 2'b00; core_partita = 2'b00;
        p1_valid = 1'b1; p1_move = 2'b01;
        tick();
        p1_valid = 1'b0;
        vectors++; if (p1_ready !== 1'b0) begin miscompares++; $display("FAIL to_p1_latched got %b want 0", p1_ready); end
        for (int i = 1; i < 4; i++) begin
            vectors++; if (p2_ready !== 1'b1) begin miscompares++; $display("FAIL to_wait_cycle%0d p2_ready got %b want 1", i, p2_ready); end
            tick();
        end
        vectors++; if (core_primo !== 2'b01) begin miscompares++; $display("FAIL to_primo got %b want 01", core_primo); end
        vectors++; if (core_secondo !== 2'b00) begin miscompares++; $display("FAIL to_secondo got %b want 00", core_secondo); end
        vectors++; if (core_inizia !== 1'b0) begin miscompares++; $display("FAIL to_inizia got %b want 0", core_inizia); end
        tick();
        vectors++; if ({res_valid, res_manche} !== 3'b100) begin miscompares++; $display("FAIL to_capture got %b want 100", {res_valid, res_manche}); end
        tick();
        vectors++; if (round_count !== 8'd1) begin miscompares++; $display("FAIL to_round_count got %0d want 1", round_count); end
    endtask

    task automatic test_double_p1();
        core_manche = 2'b11; core_partita = 2'b00;
        p1_valid = 1'b1; p1_move = 2'b11;
        tick();
        p1_move = 2'b01;
        vectors++; if (p1_ready !== 1'b0) begin miscompares++; $display("FAIL dbl_ready_a got %b want 0", p1_ready); end
        tick();
        vectors++; if (p1_ready !== 1'b0) begin miscompares++; $display("FAIL dbl_ready_b got %b want 0", p1_ready); end
        p2_valid = 1'b1; p2_move = 2'b10;
        tick();
        p2_valid = 1'b0;
        vectors++; if ({core_primo, core_secondo} !== 4'b1110) begin miscompares++; $display("FAIL dbl_issue got %b want 1110", {core_primo, core_secondo}); end
        vectors++; if (core_inizia !== 1'b0) begin miscompares++; $display("FAIL dbl_inizia got %b want 0", core_inizia); end
        tick();
        vectors++; if ({res_valid, res_manche, p1_ready} !== 4'b1110) begin miscompares++; $display("FAIL dbl_capture got %b want 1110", {res_valid, res_manche, p1_ready}); end
        p1_valid = 1'b0;
        tick();
        vectors++; if (round_count !== 8'd2) begin miscompares++; $display("FAIL dbl_round_count got %0d want 2", round_count); end
        vectors++; if (p1_ready !== 1'b1) begin miscompares++; $display("FAIL dbl_ready_after got %b want 1", p1_ready); end
    endtask

    task automatic test_match_end();
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if ({round_count, busy} !== {8'd2, 1'b1}) begin miscompares++; $display("FAIL start_ignored got %0d/%b want 2/1", round_count, busy); end
        core_manche = 2'b01; core_partita = 2'b01;
        p1_valid = 1'b1; p1_move = 2'b01;
        p2_valid = 1'b1; p2_move = 2'b11;
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        vectors++; if ({core_primo, core_secondo} !== 4'b0111) begin miscompares++; $display("FAIL end_issue got %b want 0111", {core_primo, core_secondo}); end
        tick();
        vectors++; if ({res_valid, res_partita} !== 3'b101) begin miscompares++; $display("FAIL end_capture got %b want 101", {res_valid, res_partita}); end
        tick();
        vectors++; if ({match_over, busy, p1_ready, p2_ready} !== 4'b1000) begin miscompares++; $display("FAIL done_flags got %b want 1000", {match_over, busy, p1_ready, p2_ready}); end
        vectors++; if (round_count !== 8'd3) begin miscompares++; $display("FAIL done_round_count got %0d want 3", round_count); end
        vectors++; if (res_partita !== 2'b01) begin miscompares++; $display("FAIL done_partita got %b want 01", res_partita); end
        p1_valid = 1'b1; p1_move = 2'b10;
        tick();
        vectors++; if ({match_over, p1_ready, res_valid} !== 3'b100) begin miscompares++; $display("FAIL done_hold got %b want 100", {match_over, p1_ready, res_valid}); end
        core_manche = 2'b10; core_partita = 2'b00;
        p2_valid = 1'b1; p2_move = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if ({round_count, busy, match_over} !== {8'd0, 2'b10}) begin miscompares++; $display("FAIL restart got %0d/%b/%b want 0/1/0", round_count, busy, match_over); end
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        vectors++; if ({core_primo, core_secondo, core_inizia} !== 5'b10011) begin miscompares++; $display("FAIL restart_issue got %b want 10011", {core_primo, core_secondo, core_inizia}); end
        tick(); tick();
        vectors++; if (round_count !== 8'd1) begin miscompares++; $display("FAIL restart_round_count got %0d want 1", round_count); end
    endtask

    task automatic test_reset_mid();
        p1_valid = 1'b1; p1_move = 2'b11;
        tick();
        p1_valid = 1'b0;
        vectors++; if (p1_ready !== 1'b0) begin miscompares++; $display("FAIL mid_latched got %b want 0", p1_ready); end
        rst_n = 1'b0;
        #1;
        vectors++; if ({busy, round_count} !== 9'd0) begin miscompares++; $display("FAIL mid_reset got %b/%0d want 0/0", busy, round_count); end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++; if ({busy, p1_ready} !== 2'b00) begin miscompares++; $display("FAIL mid_idle got %b want 00", {busy, p1_ready}); end
        core_manche = 2'b10; core_partita = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if (p1_ready !== 1'b1) begin miscompares++; $display("FAIL mid_latch_cleared got %b want 1", p1_ready); end
        p2_valid = 1'b1; p2_move = 2'b10;
        tick();
        p2_valid = 1'b0;
        tick(); tick(); tick();
        vectors++; if ({core_primo, core_secondo, core_inizia} !== 5'b00101) begin miscompares++; $display("FAIL mid_issue got %b want 00101", {core_primo, core_secondo, core_inizia}); end
        tick();
        vectors++; if ({res_valid, res_manche} !== 3'b110) begin miscompares++; $display("FAIL mid_capture got %b want 110", {res_valid, res_manche}); end
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_same_cycle();
        test_timeout();
        test_double_p1();
        test_match_end();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
